// File: rtl/sprite_plot_stream.sv
// Producer for the shared pixel-write port: erases a W x H sprite at its old
// position, then draws it at the new one, advancing a pixel per granted slot.
module sprite_plot_stream #(
    parameter int unsigned W     = 8,
    parameter int unsigned H     = 8,
    parameter int unsigned SCR_W = 320,
    parameter int unsigned SCR_H = 240
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] new_x,
    input  logic [7:0] new_y,
    input  logic [2:0] obj_color,
    input  logic [2:0] bg_color,
    input  logic       grant,
    output logic [8:0] VGA_X,
    output logic [7:0] VGA_Y,
    output logic [2:0] VGA_COLOR,
    output logic       plot_enable,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned RW = (H > 1) ? $clog2(H) : 1;

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [8:0]      old_x, cur_x;
    logic [7:0]      old_y, cur_y;
    logic [2:0]      obj_c, bg_c;
    logic            have_old;

    logic            in_pass;
    logic [8:0]      base_x;
    logic [7:0]      base_y;
    logic [9:0]      sum_x, sum_y;
    logic            clipped;
    logic            advance;
    logic            last_col, last_row;

    // Current pixel address, computed 10 bits wide so off-screen sums clip
    always_comb begin
        in_pass  = (state == ERASE) || (state == DRAW);
        base_x   = (state == ERASE) ? old_x : cur_x;
        base_y   = (state == ERASE) ? old_y : cur_y;
        sum_x    = 10'(base_x) + 10'(col);
        sum_y    = 10'(base_y) + 10'(row);
        clipped  = (sum_x >= 10'(SCR_W)) || (sum_y >= 10'(SCR_H));
        advance  = in_pass && (clipped || grant);
        last_col = (col == CW'(W - 1));
        last_row = (row == RW'(H - 1));
    end

    // Outputs follow the registered pixel so a pixel is visible while current
    always_comb begin
        VGA_X       = '0;
        VGA_Y       = '0;
        VGA_COLOR   = '0;
        plot_enable = 1'b0;
        busy        = (state != IDLE);
        done        = (state == DONE);
        if (in_pass) begin
            VGA_X       = sum_x[8:0];
            VGA_Y       = sum_y[7:0];
            VGA_COLOR   = (state == ERASE) ? bg_c : obj_c;
            plot_enable = !clipped;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            old_x    <= '0;
            old_y    <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            obj_c    <= '0;
            bg_c     <= '0;
            have_old <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    col <= '0;
                    row <= '0;
                    if (start) begin
                        cur_x <= new_x;
                        cur_y <= new_y;
                        obj_c <= obj_color;
                        bg_c  <= bg_color;
                        state <= have_old ? ERASE : DRAW;
                    end
                end
                ERASE, DRAW: begin
                    if (advance) begin
                        if (last_col) begin
                            col <= '0;
                            if (last_row) begin
                                row   <= '0;
                                state <= (state == ERASE) ? DRAW : DONE;
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                DONE: begin
                    old_x    <= cur_x;
                    old_y    <= cur_y;
                    have_old <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_plot_stream.sv
// Directed bench for sprite_plot_stream: draw, erase+draw, sparse grant,
// clipping, ignored start and mid-operation reset.
module tb_sprite_plot_stream;

    logic       CLOCK_50 = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [8:0] new_x = '0;
    logic [7:0] new_y = '0;
    logic [2:0] obj_color = '0;
    logic [2:0] bg_color = '0;
    logic       grant = 1'b0;
    logic [8:0] VGA_X;
    logic [7:0] VGA_Y;
    logic [2:0] VGA_COLOR;
    logic       plot_enable;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;

    logic [8:0] qx[$];
    logic [7:0] qy[$];
    logic [2:0] qc[$];
    int done_cyc, first_cyc, en_cnt, hold_err;

    sprite_plot_stream #(.W(8), .H(8), .SCR_W(320), .SCR_H(240)) dut (
        .CLOCK_50(CLOCK_50), .rst(rst), .start(start), .new_x(new_x), .new_y(new_y),
        .obj_color(obj_color), .bg_color(bg_color), .grant(grant),
        .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR),
        .plot_enable(plot_enable), .busy(busy), .done(done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic do_reset();
        rst = 1'b1;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        rst = 1'b0;
    endtask

    // Leaves the bench at the negedge of cycle 1 after the accepting edge
    task automatic do_start(input logic [8:0] x, input logic [7:0] y,
                            input logic [2:0] oc, input logic [2:0] bc);
        new_x = x; new_y = y; obj_color = oc; bg_color = bc;
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    // Records consumed pixels, done cycle and hold violations; no checking here
    task automatic run_pass(input int max_cyc, input int gper, input int spulse, input int rst_at);
        logic [8:0] px;
        logic [7:0] py;
        logic [2:0] pc;
        logic       pend;
        qx.delete(); qy.delete(); qc.delete();
        done_cyc = -1; first_cyc = -1; en_cnt = 0; hold_err = 0; pend = 1'b0;
        px = '0; py = '0; pc = '0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            grant = ((cyc % gper) == 0);
            start = (cyc == spulse);
            if (cyc == spulse) begin
                new_x = 9'd100; new_y = 8'd100; obj_color = 3'd7;
            end
            if (pend && (VGA_X !== px || VGA_Y !== py || VGA_COLOR !== pc || plot_enable !== 1'b1))
                hold_err++;
            pend = 1'b0;
            if (plot_enable === 1'b1) begin
                en_cnt++;
                if (first_cyc < 0) first_cyc = cyc;
                if (grant) begin
                    qx.push_back(VGA_X); qy.push_back(VGA_Y); qc.push_back(VGA_COLOR);
                end else begin
                    pend = 1'b1; px = VGA_X; py = VGA_Y; pc = VGA_COLOR;
                end
            end
            if (done === 1'b1) done_cyc = cyc;
            if (rst_at == cyc) rst = 1'b1;
            @(negedge CLOCK_50);
            if (done_cyc > 0 || rst_at == cyc) break;
        end
        start = 1'b0;
        grant = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (VGA_X !== 9'd0 || VGA_Y !== 8'd0 || VGA_COLOR !== 3'd0) begin
            bad++; $display("FAIL reset_xyc: got %0d,%0d,%0d want 0,0,0", VGA_X, VGA_Y, VGA_COLOR);
        end
        total++; if (plot_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_flags: got pe=%b busy=%b done=%b want 0,0,0", plot_enable, busy, done);
        end
    endtask

    task automatic test_first_draw();
        int errs;
        do_start(9'd10, 8'd20, 3'b010, 3'b001);
        total++; if (busy !== 1'b1) begin
            bad++; $display("FAIL draw_busy: got %b want 1", busy);
        end
        run_pass(200, 1, 0, 0);
        total++; if (done_cyc != 65) begin
            bad++; $display("FAIL draw_done: got %0d want 65", done_cyc);
        end
        total++; if (first_cyc != 1 || qx.size() != 64) begin
            bad++; $display("FAIL draw_count: got first=%0d n=%0d want 1,64", first_cyc, qx.size());
        end
        errs = 0;
        for (int i = 0; i < qx.size() && i < 64; i++)
            if (qx[i] !== 9'(10 + i % 8) || qy[i] !== 8'(20 + i / 8) || qc[i] !== 3'b010) errs++;
        total++; if (errs != 0) begin
            bad++; $display("FAIL draw_pixels: got %0d wrong want 0", errs);
        end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL draw_idle: got busy=%b done=%b want 0,0", busy, done);
        end
    endtask

    task automatic test_erase_draw();
        int errs;
        do_start(9'd12, 8'd20, 3'b100, 3'b000);
        run_pass(300, 1, 0, 0);
        total++; if (done_cyc != 129 || qx.size() != 128) begin
            bad++; $display("FAIL move_timing: got done=%0d n=%0d want 129,128", done_cyc, qx.size());
        end
        errs = 0;
        for (int i = 0; i < qx.size() && i < 128; i++) begin
            if (i < 64) begin
                if (qx[i] !== 9'(10 + i % 8) || qy[i] !== 8'(20 + i / 8) || qc[i] !== 3'd0) errs++;
            end else begin
                if (qx[i] !== 9'(12 + i % 8) || qy[i] !== 8'(20 + (i - 64) / 8) || qc[i] !== 3'd4) errs++;
            end
        end
        total++; if (errs != 0) begin
            bad++; $display("FAIL move_pixels: got %0d wrong want 0", errs);
        end
    endtask

    task automatic test_sparse_grant();
        int errs;
        do_start(9'd30, 8'd40, 3'd5, 3'd0);
        run_pass(1000, 4, 0, 0);
        total++; if (qx.size() != 128 || done_cyc < 0) begin
            bad++; $display("FAIL sparse_count: got n=%0d done=%0d want 128,>0", qx.size(), done_cyc);
        end
        total++; if (hold_err != 0) begin
            bad++; $display("FAIL sparse_hold: got %0d unstable cycles want 0", hold_err);
        end
        errs = 0;
        for (int i = 0; i < qx.size() && i < 128; i++) begin
            if (i < 64) begin
                if (qx[i] !== 9'(12 + i % 8) || qy[i] !== 8'(20 + i / 8) || qc[i] !== 3'd0) errs++;
            end else begin
                if (qx[i] !== 9'(30 + i % 8) || qy[i] !== 8'(40 + (i - 64) / 8) || qc[i] !== 3'd5) errs++;
            end
        end
        total++; if (errs != 0) begin
            bad++; $display("FAIL sparse_pixels: got %0d wrong want 0", errs);
        end
    endtask

    task automatic test_clip();
        int errs;
        do_reset();
        do_start(9'd316, 8'd236, 3'd7, 3'd0);
        run_pass(200, 1, 0, 0);
        total++; if (done_cyc != 65) begin
            bad++; $display("FAIL clip_done: got %0d want 65", done_cyc);
        end
        total++; if (en_cnt != 16 || qx.size() != 16) begin
            bad++; $display("FAIL clip_count: got en=%0d n=%0d want 16,16", en_cnt, qx.size());
        end
        errs = 0;
        for (int i = 0; i < qx.size() && i < 16; i++)
            if (qx[i] !== 9'(316 + i % 4) || qy[i] !== 8'(236 + i / 4) || qc[i] !== 3'd7) errs++;
        total++; if (errs != 0) begin
            bad++; $display("FAIL clip_pixels: got %0d wrong want 0", errs);
        end
    endtask

    task automatic test_start_ignored();
        int errs;
        do_start(9'd50, 8'd60, 3'd3, 3'd1);
        run_pass(300, 1, 5, 0);
        total++; if (done_cyc != 129 || qx.size() != 80) begin
            bad++; $display("FAIL ign_timing: got done=%0d n=%0d want 129,80", done_cyc, qx.size());
        end
        errs = 0;
        for (int i = 0; i < qx.size() && i < 80; i++) begin
            if (i < 16) begin
                if (qx[i] !== 9'(316 + i % 4) || qy[i] !== 8'(236 + i / 4) || qc[i] !== 3'd1) errs++;
            end else begin
                if (qx[i] !== 9'(50 + (i - 16) % 8) || qy[i] !== 8'(60 + (i - 16) / 8) || qc[i] !== 3'd3) errs++;
            end
        end
        total++; if (errs != 0) begin
            bad++; $display("FAIL ign_pixels: got %0d wrong want 0", errs);
        end
        total++; if (busy !== 1'b0) begin
            bad++; $display("FAIL ign_requeue: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_mid_reset();
        int errs;
        do_start(9'd100, 8'd100, 3'd6, 3'd2);
        // erase pass occupies cycles 1..64, so draw pixel 30 is cycle 95
        run_pass(95, 1, 0, 95);
        total++; if (VGA_X !== 9'd0 || VGA_Y !== 8'd0 || VGA_COLOR !== 3'd0 ||
                     plot_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL mrst_outputs: got x=%0d y=%0d c=%0d pe=%b busy=%b done=%b want all 0",
                            VGA_X, VGA_Y, VGA_COLOR, plot_enable, busy, done);
        end
        rst = 1'b0;
        do_start(9'd200, 8'd150, 3'd1, 3'd0);
        run_pass(200, 1, 0, 0);
        total++; if (done_cyc != 65 || qx.size() != 64) begin
            bad++; $display("FAIL mrst_drawonly: got done=%0d n=%0d want 65,64", done_cyc, qx.size());
        end
        errs = 0;
        for (int i = 0; i < qx.size() && i < 64; i++)
            if (qx[i] !== 9'(200 + i % 8) || qy[i] !== 8'(150 + i / 8) || qc[i] !== 3'd1) errs++;
        total++; if (errs != 0) begin
            bad++; $display("FAIL mrst_pixels: got %0d wrong want 0", errs);
        end
    endtask

    initial begin
        @(negedge CLOCK_50);
        test_reset();
        test_first_draw();
        test_erase_draw();
        test_sparse_grant();
        test_clip();
        test_start_ignored();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
